io_ring_pwr_seq: RTL and testbench



---
 rtl/io_ring_pkg.sv | 17 +
 rtl/io_sync2.sv | 21 ++
 rtl/io_ring_pwr_seq.sv | 158 +++++++++++++++
 tb/tb_io_ring_pwr_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/io_ring_pkg.sv
// Shared definitions for the IO-ring power sequencer: state encoding and widths.
package io_ring_pkg;

    localparam int CNT_W = 16;
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_DEBOUNCE  = 3'd1,
        ST_UNFREEZE  = 3'd2,
        ST_BANK_UP   = 3'd3,
        ST_READY     = 3'd4,
        ST_BANK_DOWN = 3'd5,
        ST_FAULT     = 3'd6
    } ring_state_e;

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for an asynchronous level, cleared to 0 by reset.
module io_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/io_ring_pwr_seq.sv
// IO-ring power sequencer: debounces supply-good, releases pad retention and
// enables pad banks one at a time, with orderly power-down and sticky fault.
import io_ring_pkg::*;

module io_ring_pwr_seq #(
    parameter int DEB_CYC = 64,
    parameter int STG_CYC = 16,
    parameter int N_BANK  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vddio_ok_i,
    input  logic              vdd_ok_i,
    input  logic              pwr_dn_req_i,
    output logic [N_BANK-1:0] bank_en_o,
    output logic              pad_ret_o,
    output logic              ring_ready_o,
    output logic              fault_o,
    output logic [2:0]        state_o
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STG_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BANK - 1);

    // Lowest n banks enabled; building enables this way keeps them gap-free.
    function automatic logic [N_BANK-1:0] therm(input logic [IDX_W:0] n);
        logic [N_BANK-1:0] m;
        m = '0;
        for (int i = 0; i < N_BANK; i++) begin
            m[i] = ((IDX_W+1)'(i) < n);
        end
        return m;
    endfunction

    logic vddio_s;
    logic vdd_s;
    logic sup_ok;

    io_sync2 u_sync_vddio (.clk(clk), .rst_n(rst_n), .d(vddio_ok_i), .q(vddio_s));
    io_sync2 u_sync_vdd   (.clk(clk), .rst_n(rst_n), .d(vdd_ok_i),   .q(vdd_s));

    assign sup_ok = vddio_s & vdd_s;

    ring_state_e       state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  idx;
    logic              stg_done;
    logic              run_st;
    logic [N_BANK-1:0] en_up;
    logic [N_BANK-1:0] en_dn;

    assign stg_done = (cnt == STG_LAST);
    assign run_st   = (state == ST_UNFREEZE) || (state == ST_BANK_UP) ||
                      (state == ST_READY)    || (state == ST_BANK_DOWN);
    assign en_up    = therm({1'b0, idx} + (IDX_W+1)'(2));
    assign en_dn    = therm({1'b0, idx});
    assign state_o  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_OFF;
            cnt          <= '0;
            idx          <= '0;
            bank_en_o    <= '0;
            pad_ret_o    <= 1'b1;
            ring_ready_o <= 1'b0;
            fault_o      <= 1'b0;
        end else if (run_st && !sup_ok) begin
            // Supply loss wins over any pending power-down request.
            state        <= ST_FAULT;
            cnt          <= '0;
            idx          <= '0;
            bank_en_o    <= '0;
            pad_ret_o    <= 1'b1;
            ring_ready_o <= 1'b0;
            fault_o      <= 1'b1;
        end else begin
            case (state)
                ST_OFF: begin
                    bank_en_o <= '0;
                    pad_ret_o <= 1'b1;
                    cnt       <= '0;
                    if (sup_ok && !pwr_dn_req_i) state <= ST_DEBOUNCE;
                end
                ST_DEBOUNCE: begin
                    if (!sup_ok) begin
                        state <= ST_OFF;
                        cnt   <= '0;
                    end else if (cnt == DEB_LAST) begin
                        state <= ST_UNFREEZE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_UNFREEZE: begin
                    if (stg_done) begin
                        state     <= ST_BANK_UP;
                        cnt       <= '0;
                        idx       <= '0;
                        bank_en_o <= therm((IDX_W+1)'(1));
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_BANK_UP: begin
                    if (stg_done) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state        <= ST_READY;
                            pad_ret_o    <= 1'b0;
                            ring_ready_o <= 1'b1;
                        end else begin
                            idx       <= idx + 1'b1;
                            bank_en_o <= en_up;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_READY: begin
                    if (pwr_dn_req_i) begin
                        state        <= ST_BANK_DOWN;
                        cnt          <= '0;
                        idx          <= IDX_LAST;
                        pad_ret_o    <= 1'b1;
                        ring_ready_o <= 1'b0;
                    end
                end
                ST_BANK_DOWN: begin
                    if (stg_done) begin
                        cnt       <= '0;
                        bank_en_o <= en_dn;
                        if (idx == '0) state <= ST_OFF;
                        else           idx   <= idx - 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (!sup_ok && pwr_dn_req_i) begin
                        state   <= ST_OFF;
                        fault_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_OFF;
                    cnt       <= '0;
                    idx       <= '0;
                    bank_en_o <= '0;
                    pad_ret_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_io_ring_pwr_seq.sv
// Directed bench for io_ring_pwr_seq with DEB_CYC=4, STG_CYC=2, N_BANK=4.
import io_ring_pkg::*;

module tb_io_ring_pwr_seq;

    localparam int DEB = 4;
    localparam int STG = 2;
    localparam int NB  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          vddio_ok_i = 1'b0;
    logic          vdd_ok_i = 1'b0;
    logic          pwr_dn_req_i = 1'b0;
    logic [NB-1:0] bank_en_o;
    logic          pad_ret_o;
    logic          ring_ready_o;
    logic          fault_o;
    logic [2:0]    state_o;

    int n_run  = 0;
    int n_fail = 0;

    io_ring_pwr_seq #(.DEB_CYC(DEB), .STG_CYC(STG), .N_BANK(NB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vddio_ok_i   (vddio_ok_i),
        .vdd_ok_i     (vdd_ok_i),
        .pwr_dn_req_i (pwr_dn_req_i),
        .bank_en_o    (bank_en_o),
        .pad_ret_o    (pad_ret_o),
        .ring_ready_o (ring_ready_o),
        .fault_o      (fault_o),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_all(input string tag, input logic [2:0] st, input logic [3:0] be,
                              input logic pr, input logic rr, input logic ft);
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".bank_en"}, 32'(bank_en_o), 32'(be));
        chk({tag, ".pad_ret"}, 32'(pad_ret_o), 32'(pr));
        chk({tag, ".ready"}, 32'(ring_ready_o), 32'(rr));
        chk({tag, ".fault"}, 32'(fault_o), 32'(ft));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2 expect_all("por", ST_OFF, 4'b0000, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick(3);
        expect_all("off_idle", ST_OFF, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Power-up: synchronizer latency 2, then 4 debounce, 2 unfreeze, 2 per bank
        vddio_ok_i = 1'b1;
        vdd_ok_i   = 1'b1;
        tick(3);
        expect_all("up_deb", ST_DEBOUNCE, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick(4);
        expect_all("up_unfrz", ST_UNFREEZE, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick(2);
        expect_all("up_b0", ST_BANK_UP, 4'b0001, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk("up_b0_hold", 32'(bank_en_o), 32'h1);
        tick(1);
        chk("up_b1", 32'(bank_en_o), 32'h3);
        tick(2);
        chk("up_b2", 32'(bank_en_o), 32'h7);
        pwr_dn_req_i = 1'b1;
        tick(2);
        expect_all("up_b3_req_ignored", ST_BANK_UP, 4'b1111, 1'b1, 1'b0, 1'b0);
        pwr_dn_req_i = 1'b0;
        tick(2);
        expect_all("up_ready", ST_READY, 4'b1111, 1'b0, 1'b1, 1'b0);

        // Orderly power-down
        pwr_dn_req_i = 1'b1;
        tick(1);
        expect_all("dn_enter", ST_BANK_DOWN, 4'b1111, 1'b1, 1'b0, 1'b0);
        tick(2);
        chk("dn_b3", 32'(bank_en_o), 32'h7);
        tick(2);
        chk("dn_b2", 32'(bank_en_o), 32'h3);
        tick(2);
        chk("dn_b1", 32'(bank_en_o), 32'h1);
        tick(2);
        expect_all("dn_off", ST_OFF, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk("off_held_by_req", 32'(state_o), 32'(ST_OFF));
        pwr_dn_req_i = 1'b0;
        tick(1);
        chk("re_deb", 32'(state_o), 32'(ST_DEBOUNCE));
        tick(4);
        chk("re_unfrz", 32'(state_o), 32'(ST_UNFREEZE));
        tick(10);
        expect_all("re_ready", ST_READY, 4'b1111, 1'b0, 1'b1, 1'b0);

        // VDDIO loss in READY
        vddio_ok_i = 1'b0;
        tick(2);
        chk("loss_pre", 32'(state_o), 32'(ST_READY));
        tick(1);
        expect_all("loss_fault", ST_FAULT, 4'b0000, 1'b1, 1'b0, 1'b1);
        tick(3);
        expect_all("fault_sticky", ST_FAULT, 4'b0000, 1'b1, 1'b0, 1'b1);
        pwr_dn_req_i = 1'b1;
        tick(1);
        expect_all("fault_exit", ST_OFF, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Reset pulse while bank 2 is enabled
        pwr_dn_req_i = 1'b0;
        vddio_ok_i   = 1'b1;
        tick(3);
        chk("r_deb", 32'(state_o), 32'(ST_DEBOUNCE));
        tick(10);
        chk("r_b2", 32'(bank_en_o), 32'h7);
        tick(1);
        #2 rst_n = 1'b0;
        #1 expect_all("async_rst", ST_OFF, 4'b0000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(3);
        chk("rst_deb", 32'(state_o), 32'(ST_DEBOUNCE));
        tick(3);
        chk("rst_deb_full", 32'(state_o), 32'(ST_DEBOUNCE));
        tick(1);
        chk("rst_unfrz", 32'(state_o), 32'(ST_UNFREEZE));
        tick(10);
        expect_all("rst_ready", ST_READY, 4'b1111, 1'b0, 1'b1, 1'b0);

        // Supply loss and power-down request seen in the same cycle
        vddio_ok_i = 1'b0;
        tick(2);
        pwr_dn_req_i = 1'b1;
        tick(1);
        expect_all("both_fault", ST_FAULT, 4'b0000, 1'b1, 1'b0, 1'b1);
        tick(1);
        expect_all("both_exit", ST_OFF, 4'b0000, 1'b1, 1'b0, 1'b0);

        // VDD glitch during debounce
        pwr_dn_req_i = 1'b0;
        vddio_ok_i   = 1'b1;
        tick(3);
        chk("g_deb", 32'(state_o), 32'(ST_DEBOUNCE));
        tick(1);
        vdd_ok_i = 1'b0;
        tick(2);
        vdd_ok_i = 1'b1;
        tick(1);
        expect_all("g_off", ST_OFF, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick(2);
        chk("g_redeb", 32'(state_o), 32'(ST_DEBOUNCE));
        tick(3);
        chk("g_deb_restart", 32'(state_o), 32'(ST_DEBOUNCE));
        tick(1);
        chk("g_unfrz", 32'(state_o), 32'(ST_UNFREEZE));
        tick(10);
        expect_all("g_ready", ST_READY, 4'b1111, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sequence did not complete by time %0t", $time);
        $fatal(1, "bench timeout");
    end

endmodule
